// File: rtl/dmem_if.sv
// dmem_if: valid/ready request and pulsed response bundle for dmem_ctrl.
interface dmem_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [2:0]  req_type;
  logic [31:0] req_wdata;
  logic [31:0] req_pc;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  modport master (output req_valid, req_we, req_addr, req_type, req_wdata, req_pc,
                  input  req_ready, rsp_valid, rsp_rdata, rsp_err);
  modport slave  (input  req_valid, req_we, req_addr, req_type, req_wdata, req_pc,
                  output req_ready, rsp_valid, rsp_rdata, rsp_err);
endinterface

// File: rtl/dmem_ctrl.sv
// dmem_ctrl: RV32 data memory with byte/half/word access, fault reporting and pipelined response.
// Define DMEM_MISALIGN_SPLIT_EN to run misaligned half/word accesses as two word beats.
module dmem_ctrl #(
  parameter int DEPTH_WORDS = 256,
  parameter int RD_LAT      = 1,
  parameter bit TRACE       = 0
) (
  input logic   clk,
  input logic   rst,
  dmem_if.slave bus
);
  localparam int AW = $clog2(DEPTH_WORDS);
  typedef enum logic [1:0] {IDLE, ACC, BEAT2, OUT} state_t;
  state_t state_q, state_d;
  logic [31:0] ram [DEPTH_WORDS];
  logic          we_q, we_d, err_q, err_d, split_q, split_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [1:0]    off_q, off_d;
  logic [2:0]    type_q, type_d;
  logic [31:0]   wdata_q, wdata_d, pc_q, pc_d, lo_q, lo_d;
  logic          accept, resp, in0, bad_t, mis, fault, split;
  logic          wr_en;
  logic [AW-1:0] wr_idx, idx_n;
  logic [3:0]    mask4, wr_be;
  logic [7:0]    be8;
  logic [31:0]   wfull, wr_data, wr_word, wr_mask, rd_lo, rd_hi, sh, ext;
  logic [63:0]   wd64;
  assign in0   = {2'b00, bus.req_addr[31:2]} < 32'(DEPTH_WORDS);
  assign bad_t = bus.req_type[1:0] == 2'b11;
  assign mis   = (bus.req_type[1:0] == 2'b01 && bus.req_addr[0]) ||
                 (bus.req_type[1:0] == 2'b10 && bus.req_addr[1:0] != 2'b00);
`ifdef DMEM_MISALIGN_SPLIT_EN
  logic in1;
  assign in1   = {2'b00, bus.req_addr[31:2]} + 32'd1 < 32'(DEPTH_WORDS);
  assign split = mis && in0 && in1;
  assign fault = bad_t || !in0 || (mis && !in1);
`else
  assign split = 1'b0;
  assign fault = bad_t || !in0 || mis;
`endif
  assign resp   = state_q == OUT ||
                  (RD_LAT == 1 && (state_q == BEAT2 || (state_q == ACC && !split_q)));
  assign accept = bus.req_valid && bus.req_ready;
  always_ff @(posedge clk or posedge rst)
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  always_comb
    state_d = (state_q == IDLE || resp) ? (accept ? ACC : IDLE) :
              (state_q == ACC && split_q) ? BEAT2 : OUT;
  always_comb begin
    we_d    = accept ? bus.req_we : we_q;
    err_d   = accept ? fault : err_q;
    split_d = accept ? split : split_q;
    idx_d   = accept ? bus.req_addr[AW+1:2] : idx_q;
    off_d   = accept ? bus.req_addr[1:0] : off_q;
    type_d  = accept ? bus.req_type : type_q;
    wdata_d = accept ? bus.req_wdata : wdata_q;
    pc_d    = accept ? bus.req_pc : pc_q;
    lo_d    = state_q == ACC ? ram[idx_q] : lo_q;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      we_q <= 1'b0; err_q <= 1'b0; split_q <= 1'b0; idx_q <= '0; off_q <= '0;
      type_q <= '0; wdata_q <= '0; pc_q <= '0; lo_q <= '0;
    end else begin
      we_q <= we_d; err_q <= err_d; split_q <= split_d; idx_q <= idx_d; off_q <= off_d;
      type_q <= type_d; wdata_q <= wdata_d; pc_q <= pc_d; lo_q <= lo_d;
    end
  // Lanes are built as a 64-bit window so aligned and split accesses share one path
  always_comb begin
    idx_n   = idx_q + 1'b1;
    mask4   = type_q[1:0] == 2'b00 ? 4'h1 : type_q[1:0] == 2'b01 ? 4'h3 : 4'hF;
    wfull   = type_q[1:0] == 2'b00 ? {24'd0, wdata_q[7:0]} :
              type_q[1:0] == 2'b01 ? {16'd0, wdata_q[15:0]} : wdata_q;
    wd64    = {32'd0, wfull} << {off_q, 3'b000};
    be8     = {4'd0, mask4} << off_q;
    wr_en   = we_q && !err_q && (state_q == ACC || state_q == BEAT2);
    wr_idx  = state_q == BEAT2 ? idx_n : idx_q;
    wr_data = state_q == BEAT2 ? wd64[63:32] : wd64[31:0];
    wr_be   = state_q == BEAT2 ? be8[7:4] : be8[3:0];
    wr_mask = {{8{wr_be[3]}}, {8{wr_be[2]}}, {8{wr_be[1]}}, {8{wr_be[0]}}};
    wr_word = (ram[wr_idx] & ~wr_mask) | (wr_data & wr_mask);
    rd_lo   = split_q ? lo_q : ram[idx_q];
    rd_hi   = split_q ? ram[idx_n] : 32'd0;
    sh      = 32'({rd_hi, rd_lo} >> {off_q, 3'b000});
    ext     = type_q[1:0] == 2'b00 ? {{24{!type_q[2] && sh[7]}}, sh[7:0]} :
              type_q[1:0] == 2'b01 ? {{16{!type_q[2] && sh[15]}}, sh[15:0]} : sh;
    bus.req_ready = state_q == IDLE || resp;
    bus.rsp_valid = resp;
    bus.rsp_err   = resp && err_q;
    bus.rsp_rdata = (resp && !we_q && !err_q) ? ext : 32'd0;
  end
  always_ff @(posedge clk)
    if (wr_en) ram[wr_idx] <= wr_word;
`ifndef SYNTHESIS
  if (TRACE) begin : g_trace
    always @(posedge clk)
      if (!rst && wr_en) $display("dmem st pc=%h addr=%h data=%h", pc_q, 32'({wr_idx, 2'b00}), wr_word);
  end
`endif
endmodule

// File: tb/tb_dmem_ctrl.sv
// tb_dmem_ctrl: directed vectors with hand-computed expectations for dmem_ctrl.
module tb_dmem_ctrl;
  localparam int L = 1;
`ifdef DMEM_MISALIGN_SPLIT_EN
  localparam bit SPL = 1;
`else
  localparam bit SPL = 0;
`endif
  localparam logic [2:0] LB = 3'b000, LH = 3'b001, LW = 3'b010, LBU = 3'b100, LHU = 3'b101, BAD = 3'b011;
  logic clk = 0, rst = 1;
  int n_cmp = 0, n_bad = 0;
  dmem_if bus();
  dmem_ctrl #(.DEPTH_WORDS(256), .RD_LAT(L), .TRACE(0)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic xfer(input logic we, input logic [31:0] a, input logic [2:0] t, input logic [31:0] wd,
                      output logic [31:0] rd, output logic er, output int lat);
    int n = 0;
    @(negedge clk);
    bus.req_valid = 1; bus.req_we = we; bus.req_addr = a; bus.req_type = t; bus.req_wdata = wd;
    bus.req_pc = 32'h1000 + a;
    while (!bus.req_ready && n < 10) begin @(negedge clk); n++; end
    @(posedge clk); #1 bus.req_valid = 0;
    lat = -1; rd = 0; er = 0;
    for (int c = 1; c <= 10 && lat < 0; c++) begin
      @(negedge clk);
      if (bus.rsp_valid) begin lat = c; rd = bus.rsp_rdata; er = bus.rsp_err; end
    end
  endtask
  task automatic ld(input string tag, input logic [31:0] a, input logic [2:0] t,
                    input logic [31:0] exp, input logic e, input int l);
    logic [31:0] rd; logic er; int lat;
    xfer(1'b0, a, t, 32'd0, rd, er, lat);
    chk({tag, ".data"}, rd, exp);
    chk({tag, ".err"}, {31'd0, er}, {31'd0, e});
    chk({tag, ".lat"}, 32'(lat), 32'(l));
  endtask
  task automatic st(input string tag, input logic [31:0] a, input logic [2:0] t,
                    input logic [31:0] wd, input logic e, input int l);
    logic [31:0] rd; logic er; int lat;
    xfer(1'b1, a, t, wd, rd, er, lat);
    chk({tag, ".data"}, rd, 32'd0);
    chk({tag, ".err"}, {31'd0, er}, {31'd0, e});
    chk({tag, ".lat"}, 32'(lat), 32'(l));
  endtask
  initial begin
    logic [31:0] w100, w104;
    logic [31:0] ba [4];
    logic [31:0] be [4];
    int i, r, seen;
    bus.req_valid = 0; bus.req_we = 0; bus.req_addr = 0; bus.req_type = 0; bus.req_wdata = 0; bus.req_pc = 0;
    repeat (2) @(negedge clk);
    chk("rst.ready", {31'd0, bus.req_ready}, 32'd1);
    chk("rst.valid", {31'd0, bus.rsp_valid}, 32'd0);
    chk("rst.rdata", bus.rsp_rdata, 32'd0);
    chk("rst.err",   {31'd0, bus.rsp_err}, 32'd0);
    rst = 0;
    st("sw100", 32'h100, LW, 32'hDEADBEEF, 0, L);
    ld("lw100", 32'h100, LW, 32'hDEADBEEF, 0, L);
    st("sb103", 32'h103, LB, 32'h00000080, 0, L);
    ld("lw100b", 32'h100, LW, 32'h80ADBEEF, 0, L);
    ld("lb103",  32'h103, LB, 32'hFFFFFF80, 0, L);
    ld("lbu103", 32'h103, LBU, 32'h00000080, 0, L);
    ld("lhu102", 32'h102, LHU, 32'h000080AD, 0, L);
    ld("lh102",  32'h102, LH, 32'hFFFF80AD, 0, L);
    st("sh100", 32'h100, LH, 32'hFFFF5566, 0, L);
    ld("lw100c", 32'h100, LW, 32'h80AD5566, 0, L);
    st("sw3fc", 32'h3FC, LW, 32'h12345678, 0, L);
    ld("lw400", 32'h400, LW, 32'd0, 1, L);
    st("sw400", 32'h400, LW, 32'hCAFEF00D, 1, L);
    ld("lw3fc", 32'h3FC, LW, 32'h12345678, 0, L);
    ld("lw100d", 32'h100, LW, 32'h80AD5566, 0, L);
    ld("rsvd", 32'h100, BAD, 32'd0, 1, L);
    st("rsvd_st", 32'h100, BAD, 32'h0, 1, L);
    ld("lw100e", 32'h100, LW, 32'h80AD5566, 0, L);
    st("sw100f", 32'h100, LW, 32'h33221100, 0, L);
    st("sw104", 32'h104, LW, 32'h77665544, 0, L);
    ld("lw102", 32'h102, LW, SPL ? 32'h55443322 : 32'd0, !SPL, SPL ? L + 1 : L);
    ld("lhu105", 32'h105, LHU, SPL ? 32'h00006655 : 32'd0, !SPL, SPL ? L + 1 : L);
    st("sh103", 32'h103, LH, 32'h0000AABB, !SPL, SPL ? L + 1 : L);
    w100 = SPL ? 32'hBB221100 : 32'h33221100;
    w104 = SPL ? 32'h776655AA : 32'h77665544;
    ld("lw100g", 32'h100, LW, w100, 0, L);
    ld("lw104g", 32'h104, LW, w104, 0, L);
    st("sw3fd", 32'h3FD, LW, 32'h0, 1, L);
    ld("lw3fcb", 32'h3FC, LW, 32'h12345678, 0, L);
    ba = '{32'h100, 32'h104, 32'h3FC, 32'h100};
    be = '{w100, w104, 32'h12345678, w100};
    i = 0; r = 0;
    for (int c = 0; c < 40 && r < 4; c++) begin
      @(negedge clk);
      if (bus.rsp_valid) begin
        chk($sformatf("b2b%0d.data", r), bus.rsp_rdata, be[r]);
        chk($sformatf("b2b%0d.err", r), {31'd0, bus.rsp_err}, 32'd0);
        r++;
      end
      bus.req_valid = i < 4; bus.req_we = 0; bus.req_type = LW;
      if (i < 4) bus.req_addr = ba[i];
      if (i < 4 && bus.req_ready) i++;
    end
    bus.req_valid = 0;
    chk("b2b.count", 32'(r), 32'd4);
    @(negedge clk);
    chk("b2b.extra", {31'd0, bus.rsp_valid}, 32'd0);
    @(negedge clk);
    bus.req_valid = 1; bus.req_we = 0; bus.req_addr = 32'h104; bus.req_type = LW;
    @(posedge clk); #1 bus.req_valid = 0; rst = 1;
    #1;
    chk("mrst.ready", {31'd0, bus.req_ready}, 32'd1);
    chk("mrst.valid", {31'd0, bus.rsp_valid}, 32'd0);
    chk("mrst.rdata", bus.rsp_rdata, 32'd0);
    chk("mrst.err",   {31'd0, bus.rsp_err}, 32'd0);
    seen = 0;
    repeat (2) begin @(negedge clk); if (bus.rsp_valid) seen++; end
    rst = 0;
    repeat (2) begin @(negedge clk); if (bus.rsp_valid) seen++; end
    chk("mrst.norsp", 32'(seen), 32'd0);
    ld("lw3fcr", 32'h3FC, LW, 32'h12345678, 0, L);
    ld("lw104r", 32'h104, LW, w104, 0, L);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
